// File: rtl/nmi_copy_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nmi_copy_initiator                                           |
// | Description : NMI master that copies len_words 32-bit words src -> dst     |
// |               using alternating read/write transactions on one port.       |
// | Config      : NMI_COPY_TIMEOUT_EN enables the ready-wait timeout abort.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nmi_copy_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int WSTRB_WIDTH    = (DATA_WIDTH-1)/8+1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [LEN_WIDTH-1:0]   len_words,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   m_nmi_valid,
    output logic                   m_nmi_instr,
    input  logic                   m_nmi_ready,
    output logic [ADDR_WIDTH-1:0]  m_nmi_addr,
    output logic [DATA_WIDTH-1:0]  m_nmi_wdata,
    output logic [WSTRB_WIDTH-1:0] m_nmi_wstrb,
    input  logic [DATA_WIDTH-1:0]  m_nmi_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_WORD_BYTES = ADDR_WIDTH'(4);

    logic [1:0]             r_state,   w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_src_ptr, w_src_ptr_nxt;
    logic [ADDR_WIDTH-1:0]  r_dst_ptr, w_dst_ptr_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr,    w_addr_nxt;
    logic [LEN_WIDTH-1:0]   r_count,   w_count_nxt;
    logic [DATA_WIDTH-1:0]  r_buffer,  w_buffer_nxt;
    logic [DATA_WIDTH-1:0]  r_wdata,   w_wdata_nxt;
    logic [WSTRB_WIDTH-1:0] r_wstrb,   w_wstrb_nxt;
    logic                   r_valid,   w_valid_nxt;
    logic                   r_busy,    w_busy_nxt;
    logic                   r_done,    w_done_nxt;

    logic                   w_hs;
    logic                   w_last;
    logic                   w_timeout;
    logic                   w_start_copy;
    logic [ADDR_WIDTH-1:0]  w_src_aligned;
    logic [ADDR_WIDTH-1:0]  w_dst_aligned;

    assign w_hs          = r_valid && m_nmi_ready;
    assign w_last        = (r_count == LEN_WIDTH'(1));
    assign w_start_copy  = start && (len_words != '0);
    assign w_src_aligned = {src_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_dst_aligned = {dst_addr[ADDR_WIDTH-1:2], 2'b00};

    // State and all output/datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_ST_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_buffer  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_src_ptr <= w_src_ptr_nxt;
            r_dst_ptr <= w_dst_ptr_nxt;
            r_addr    <= w_addr_nxt;
            r_count   <= w_count_nxt;
            r_buffer  <= w_buffer_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_copy) w_state_nxt = c_ST_RD;
            c_ST_RD: begin
                if (w_timeout)  w_state_nxt = c_ST_DONE;
                else if (w_hs)  w_state_nxt = c_ST_WR;
            end
            c_ST_WR: begin
                if (w_timeout)  w_state_nxt = c_ST_DONE;
                else if (w_hs)  w_state_nxt = w_last ? c_ST_DONE : c_ST_RD;
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; valid stays high across RD->WR->RD
    always_comb begin
        w_src_ptr_nxt = r_src_ptr;
        w_dst_ptr_nxt = r_dst_ptr;
        w_addr_nxt    = r_addr;
        w_count_nxt   = r_count;
        w_buffer_nxt  = r_buffer;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_copy) begin
                    w_src_ptr_nxt = w_src_aligned;
                    w_dst_ptr_nxt = w_dst_aligned;
                    w_count_nxt   = len_words;
                    w_addr_nxt    = w_src_aligned;
                    w_wstrb_nxt   = '0;
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                end else if (start) begin
                    w_done_nxt    = 1'b1;
                end
            end
            c_ST_RD: begin
                if (w_timeout) begin
                    w_valid_nxt  = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (w_hs) begin
                    w_buffer_nxt = m_nmi_rdata;
                    w_wdata_nxt  = m_nmi_rdata;
                    w_addr_nxt   = r_dst_ptr;
                    w_wstrb_nxt  = '1;
                end
            end
            c_ST_WR: begin
                if (w_timeout) begin
                    w_valid_nxt   = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                end else if (w_hs) begin
                    w_src_ptr_nxt = r_src_ptr + c_WORD_BYTES;
                    w_dst_ptr_nxt = r_dst_ptr + c_WORD_BYTES;
                    w_count_nxt   = r_count - LEN_WIDTH'(1);
                    w_wstrb_nxt   = '0;
                    if (w_last) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt  = r_src_ptr + c_WORD_BYTES;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef NMI_COPY_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle
    assign w_timeout = r_valid && !m_nmi_ready &&
                       (r_wait == c_WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_timeout)
                r_err <= 1'b1;
            else if ((r_state == c_ST_IDLE) && start)
                r_err <= 1'b0;

            if (w_hs || (w_state_nxt != r_state))
                r_wait <= '0;
            else if (r_valid && !m_nmi_ready)
                r_wait <= r_wait + c_WAIT_W'(1);
        end
    end

    assign err = r_err;

    logic w_unused;
    assign w_unused = ^{src_addr[1:0], dst_addr[1:0]};
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;

    logic w_unused;
    assign w_unused = ^{src_addr[1:0], dst_addr[1:0]} ^ (TIMEOUT_CYCLES != 0);
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign m_nmi_valid = r_valid;
    assign m_nmi_instr = 1'b0;
    assign m_nmi_addr  = r_addr;
    assign m_nmi_wdata = r_wdata;
    assign m_nmi_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_nmi_copy_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nmi_copy_initiator                                        |
// | Description : Directed self-checking bench with a small NMI memory model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nmi_copy_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len_words = '0;
    logic          busy, done, err;
    logic          m_nmi_valid, m_nmi_instr;
    logic          m_nmi_ready = 1'b1;
    logic [AW-1:0] m_nmi_addr;
    logic [DW-1:0] m_nmi_wdata;
    logic [SW-1:0] m_nmi_wstrb;
    logic [DW-1:0] m_nmi_rdata;

    logic [31:0]   mem [0:255];
    int            checks = 0;
    int            failures = 0;
    bit            rand_ready = 1'b0;
    logic          ready_fix = 1'b1;

    int            stall_viol = 0;
    int            hs_cnt = 0;
    int            valid_cnt = 0;
    int            done_cnt = 0;
    logic [31:0]   rd_log [$];
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_addr = '0;
    logic [31:0]   prev_wdata = '0;
    logic [3:0]    prev_wstrb = '0;

    always #5 clk = ~clk;

    nmi_copy_initiator #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .LEN_WIDTH      (LW),
        .WSTRB_WIDTH    (SW),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len_words   (len_words),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .m_nmi_valid (m_nmi_valid),
        .m_nmi_instr (m_nmi_instr),
        .m_nmi_ready (m_nmi_ready),
        .m_nmi_addr  (m_nmi_addr),
        .m_nmi_wdata (m_nmi_wdata),
        .m_nmi_wstrb (m_nmi_wstrb),
        .m_nmi_rdata (m_nmi_rdata)
    );

    // Memory responder: 256 words indexed by address bits [9:2]
    always_comb m_nmi_rdata = mem[m_nmi_addr[9:2]];

    always @(posedge clk) begin
        if (rstn && m_nmi_valid && m_nmi_ready && (m_nmi_wstrb == 4'hF))
            mem[m_nmi_addr[9:2]] <= m_nmi_wdata;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_nmi_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Bus monitor: stall stability, handshake and read-address log
    always @(negedge clk) begin
        if (rstn && prev_stall &&
            (!m_nmi_valid || m_nmi_addr !== prev_addr ||
             m_nmi_wdata !== prev_wdata || m_nmi_wstrb !== prev_wstrb))
            stall_viol++;
        prev_stall = rstn && m_nmi_valid && !m_nmi_ready;
        prev_addr  = m_nmi_addr;
        prev_wdata = m_nmi_wdata;
        prev_wstrb = m_nmi_wstrb;
        if (m_nmi_valid) valid_cnt++;
        if (done)        done_cnt++;
        if (m_nmi_valid && m_nmi_ready) begin
            hs_cnt++;
            if (m_nmi_wstrb == 4'h0) rd_log.push_back(m_nmi_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int first_v, output int done_at,
                               output int vcyc, output logic busy_first);
        first_v    = -1;
        done_at    = -1;
        vcyc       = 0;
        busy_first = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                done_at = i;
                break;
            end
            if (m_nmi_valid) begin
                if (first_v < 0) begin
                    first_v    = i;
                    busy_first = busy;
                end
                vcyc++;
            end
            tick();
        end
    endtask

    initial begin
        int   first_v, done_at, vcyc, v0, d0, h0, sv0, errs, n;
        logic busy_first;

        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;

        // Reset
        repeat (3) tick();
        check_eq("rst_busy",  busy,        0);
        check_eq("rst_done",  done,        0);
        check_eq("rst_err",   err,         0);
        check_eq("rst_valid", m_nmi_valid, 0);
        check_eq("rst_wstrb", m_nmi_wstrb, 0);
        check_eq("rst_addr",  m_nmi_addr,  0);
        rstn = 1'b1;
        tick();

        // 4 words 0x100 -> 0x200, zero-wait responder
        for (int i = 0; i < 4; i++) begin
            mem[64 + i]  <= 32'hA0 + i;
            mem[128 + i] <= 32'h0;
        end
        tick();
        do_start(32'h100, 32'h200, 16'd4);
        check_eq("A_first_addr", m_nmi_addr, 32'h100);
        check_eq("A_instr", m_nmi_instr, 0);
        run_to_done(40, first_v, done_at, vcyc, busy_first);
        check_eq("A_done_seen", done, 1);
        check_eq("A_first_valid", first_v, 0);
        check_eq("A_busy_during", busy_first, 1);
        check_eq("A_done_latency", done_at - first_v, 8);
        check_eq("A_valid_cycles", vcyc, 8);
        check_eq("A_busy_at_done", busy, 0);
        check_eq("A_err", err, 0);
        tick();
        check_eq("A_done_pulse", done, 0);
        check_eq("A_busy_after", busy, 0);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("A_dst%0d", i), mem[128 + i], 32'hA0 + i);

        // Zero-length start
        v0 = valid_cnt;
        d0 = done_cnt;
        do_start(32'h100, 32'h200, 16'd0);
        check_eq("B_done", done, 1);
        check_eq("B_busy", busy, 0);
        tick();
        check_eq("B_done_pulse", done, 0);
        repeat (4) tick();
        check_eq("B_no_valid", valid_cnt - v0, 0);
        check_eq("B_done_count", done_cnt - d0, 1);

        // 16 words with random backpressure
        for (int i = 0; i < 16; i++) begin
            mem[64 + i]  <= 32'h5A00_0000 + i * 32'h1111;
            mem[128 + i] <= 32'h0;
        end
        rand_ready = 1'b1;
        tick();
        sv0 = stall_viol;
        h0  = hs_cnt;
        do_start(32'h100, 32'h200, 16'd16);
        run_to_done(2000, first_v, done_at, vcyc, busy_first);
        check_eq("C_done_seen", done, 1);
        rand_ready = 1'b0;
        ready_fix  = 1'b1;
        check_eq("C_stall_stable", stall_viol - sv0, 0);
        check_eq("C_handshakes", hs_cnt - h0, 32);
        errs = 0;
        for (int i = 0; i < 16; i++)
            if (mem[128 + i] !== 32'h5A00_0000 + i * 32'h1111) errs++;
        check_eq("C_data_errs", errs, 0);
        tick();
        tick();

        // Address wrap, with a start pulse mid-copy that must be ignored
        mem[254] <= 32'h1111_1111;
        mem[255] <= 32'h2222_2222;
        mem[0]   <= 32'h3333_3333;
        for (int i = 192; i < 200; i++) mem[i] <= 32'h0;
        tick();
        rd_log.delete();
        do_start(32'hFFFF_FFF8, 32'h300, 16'd3);
        tick();
        tick();
        check_eq("D_busy_mid", busy, 1);
        src_addr  = 32'h40;
        len_words = 16'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        run_to_done(100, first_v, done_at, vcyc, busy_first);
        check_eq("D_done_seen", done, 1);
        n = rd_log.size();
        check_eq("D_reads", n, 3);
        if (n == 3) begin
            check_eq("D_rd0", rd_log[0], 32'hFFFF_FFF8);
            check_eq("D_rd1", rd_log[1], 32'hFFFF_FFFC);
            check_eq("D_rd2", rd_log[2], 32'h0000_0000);
        end
        check_eq("D_dst0", mem[192], 32'h1111_1111);
        check_eq("D_dst1", mem[193], 32'h2222_2222);
        check_eq("D_dst2", mem[194], 32'h3333_3333);
        check_eq("D_dst3", mem[195], 32'h0);
        v0 = valid_cnt;
        repeat (5) tick();
        check_eq("D_start_not_queued", valid_cnt - v0, 0);

        // Reset in the middle of a copy
        do_start(32'h100, 32'h200, 16'd8);
        repeat (3) tick();
        check_eq("E_valid_mid", m_nmi_valid, 1);
        d0 = done_cnt;
        rstn = 1'b0;
        #1;
        check_eq("E_busy",  busy,        0);
        check_eq("E_valid", m_nmi_valid, 0);
        check_eq("E_addr",  m_nmi_addr,  0);
        check_eq("E_wdata", m_nmi_wdata, 0);
        check_eq("E_wstrb", m_nmi_wstrb, 0);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (3) tick();
        check_eq("E_no_done", done_cnt - d0, 0);
        check_eq("E_idle_valid", m_nmi_valid, 0);

`ifdef NMI_COPY_TIMEOUT_EN
        // Responder never ready: abort after 256 stalled cycles
        ready_fix = 1'b0;
        tick();
        tick();
        do_start(32'h100, 32'h200, 16'd2);
        n = 0;
        while (m_nmi_valid && n < 400) begin
            tick();
            n++;
        end
        check_eq("F_stall_cycles", n, 256);
        check_eq("F_err",  err,  1);
        check_eq("F_done", done, 1);
        check_eq("F_busy", busy, 0);
        ready_fix = 1'b1;
        tick();
        check_eq("F_done_pulse", done, 0);
        check_eq("F_err_sticky", err, 1);
        do_start(32'h0, 32'h0, 16'd0);
        check_eq("F_err_cleared", err, 0);
        check_eq("F_done_len0", done, 1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
